alu_op_issue: RTL and testbench
===============================

Name: alu_op_issue

Overview:
- Producer side of the N-bit ALU's sel/A/B interface: decodes the main control's ALUOp plus instruction funct fields into the 4-bit ALU select code.
- Registers the decoded sel together with operands A and B into a 2-entry skid buffer using a valid/ready handshake.
- Sits between the decode stage and the ALU; supports back-pressure from the execute stage and pipeline flush.
- Counts illegal encodings for debug.

Parameters:
- N, 32, operand width of A/B (matches ALU width)
- CNT_W, 16, width of illegal-op saturating counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an operation
- in_ready  out  1  block can accept an operation this cycle
- alu_op  in  2  main-control ALUOp: 00 load/store, 01 branch, 10 R-type, 11 I-type
- funct3  in  3  instruction funct3
- funct7_5  in  1  instruction bit 30
- opa  in  N  operand A
- opb  in  N  operand B
- flush  in  1  discard all buffered operations
- out_valid  out  1  sel/A/B valid to ALU stage
- out_ready  in  1  ALU stage accepts this cycle
- sel  out  4  ALU select code
- A  out  N  operand A to ALU
- B  out  N  operand B to ALU
- illegal  out  1  current output entry was an illegal encoding
- illegal_cnt  out  CNT_W  saturating count of accepted illegal ops

Behaviour:
- Reset, asynchronous on rst_n low: both buffer entries empty; out_valid=0, in_ready=1, sel=4'b1111, A=0, B=0, illegal=0, illegal_cnt=0.
- Decode, combinational on inputs; result captured on accept:
  - ALUOp 00 -> 0010 (add)
  - ALUOp 01 -> 0110 (sub)
  - ALUOp 10, funct3 000 -> funct7_5 ? 0110 : 0010
  - ALUOp 10, funct3 111 -> 0000 (and)
  - ALUOp 10, funct3 110 -> 0001 (or)
  - ALUOp 11, funct3 000 -> 0010 (funct7_5 ignored)
  - ALUOp 11, funct3 111 -> 0000
  - ALUOp 11, funct3 110 -> 0001
  - Any other combination: illegal; sel=1111. The ALU produces 0 for this code, which is intended.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready is a registered signal equal to "skid entry empty". It never depends combinationally on out_ready.
- Storage, 2 entries: main (drives outputs) and skid.
  - Main empty, or main transferring this cycle: an accepted op loads main.
  - Main full and not transferring: an accepted op loads skid, and in_ready drops next cycle.
  - When main transfers and skid is full, skid moves to main, skid empties, and in_ready rises next cycle.
  - Ordering is strictly FIFO.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 op/cycle with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, sel/A/B/illegal hold constant.
- flush:
  - Synchronous. Next cycle both entries are empty, out_valid=0, sel=1111.
  - An op presented in the flush cycle is dropped and not counted, even if in_ready=1.
  - An output transfer in the flush cycle still counts as completed by the consumer.
- illegal_cnt:
  - Increments by 1 on each accepted illegal op that is not dropped by flush.
  - Saturates at all-ones.
  - Not cleared by flush.
- Mid-operation reset clears everything immediately, regardless of clk.
- When out_valid=0, outputs hold sel=1111 and the last A/B values. The consumer must ignore them.

Decomposition:
- Shared package alu_pkg:
  - ALU sel constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_NOP=1111
  - ALUOp encodings: 00/01/10/11
  - funct3 constants: F3_ADDSUB=000, F3_AND=111, F3_OR=110
- One sub-module, alu_op_decode: purely combinational, (alu_op, funct3, funct7_5) -> (sel, illegal).
- The top level holds the skid buffer, handshake and counter.

Test Plan:
- Decode sweep: each of the 32 {alu_op,funct3} combinations with funct7_5 = 0 and 1, out_ready=1 -> sel per table one cycle after accept. Example: alu_op=10, f3=000, f7_5=1 -> sel=0110. Also alu_op=10, f3=001 -> sel=1111, illegal=1.
- Back-pressure: out_ready=0, send ops X (opa=5, opb=3, add) then Y (opa=5, opb=3, sub) -> in_ready=0 after Y, outputs hold X. Release out_ready -> X then Y on consecutive cycles, in_ready returns to 1.
- Streaming: 100 random legal ops with in_valid and out_ready both held 1 -> one output per cycle, same order, no bubbles after the first-cycle latency.
- Flush with both entries full, plus a new op in the same cycle -> next cycle out_valid=0, in_ready=1. The new op is never emitted and illegal_cnt is unchanged.
- Counter saturation with CNT_W=4: 20 illegal ops -> illegal_cnt stops at 15.
- Async reset asserted between clock edges while the buffer is full -> outputs reach their reset values immediately. First op after rst_n deassertion emerges 1 cycle after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU select interface and its main-control inputs.
package alu_pkg;

  // ALU select codes; ALU_NOP makes the ALU produce zero.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // Main-control ALUOp field.
  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ITYPE  = 2'b11
  } alu_op_e;

  // funct3 values the decoder understands.
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decode into the 4-bit ALU select code.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] sel,
  output logic       illegal
);

  // Unlisted combinations fall through to the NOP code and are flagged illegal.
  always_comb begin
    sel     = ALU_NOP;
    illegal = 1'b1;
    case (alu_op)
      OP_MEM: begin
        sel     = ALU_ADD;
        illegal = 1'b0;
      end
      OP_BRANCH: begin
        sel     = ALU_SUB;
        illegal = 1'b0;
      end
      OP_RTYPE, OP_ITYPE: begin
        case (funct3)
          F3_ADDSUB: begin
            // Immediate forms have no subtract, so bit 30 only matters for R-type.
            sel     = ((alu_op == OP_RTYPE) && funct7_5) ? ALU_SUB : ALU_ADD;
            illegal = 1'b0;
          end
          F3_AND: begin
            sel     = ALU_AND;
            illegal = 1'b0;
          end
          F3_OR: begin
            sel     = ALU_OR;
            illegal = 1'b0;
          end
          default: begin
            sel     = ALU_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        sel     = ALU_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage towards the ALU: decodes the operation and holds it, with its
// operands, in a 2-entry skid buffer (main drives the outputs, skid catches
// the op accepted while main is stalled). Also counts illegal encodings.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [N-1:0]     opa,
  input  logic [N-1:0]     opb,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       sel,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [3:0]       w_dec_sel;
  logic             w_dec_ill;
  logic             w_acc;
  logic             w_xfer;

  logic             r_main_v;
  logic [3:0]       r_main_sel;
  logic [N-1:0]     r_main_a;
  logic [N-1:0]     r_main_b;
  logic             r_main_ill;

  logic             r_skid_v;
  logic [3:0]       r_skid_sel;
  logic [N-1:0]     r_skid_a;
  logic [N-1:0]     r_skid_b;
  logic             r_skid_ill;

  logic [CNT_W-1:0] r_cnt;

  alu_op_decode u_decode (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .sel      (w_dec_sel),
    .illegal  (w_dec_ill)
  );

  // Ready only reflects the skid register, so out_ready never reaches in_ready.
  assign in_ready = ~r_skid_v;
  assign w_acc    = in_valid && in_ready && !flush;
  assign w_xfer   = r_main_v && out_ready;

  // Skid buffer: main refills from skid first (FIFO order), else from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v   <= 1'b0;
      r_main_sel <= ALU_NOP;
      r_main_a   <= '0;
      r_main_b   <= '0;
      r_main_ill <= 1'b0;
      r_skid_v   <= 1'b0;
      r_skid_sel <= ALU_NOP;
      r_skid_a   <= '0;
      r_skid_b   <= '0;
      r_skid_ill <= 1'b0;
    end else if (flush) begin
      // Operands are left as-is; only the select is parked on NOP.
      r_main_v   <= 1'b0;
      r_main_sel <= ALU_NOP;
      r_main_ill <= 1'b0;
      r_skid_v   <= 1'b0;
    end else if (!r_main_v || w_xfer) begin
      if (r_skid_v) begin
        r_main_v   <= 1'b1;
        r_main_sel <= r_skid_sel;
        r_main_a   <= r_skid_a;
        r_main_b   <= r_skid_b;
        r_main_ill <= r_skid_ill;
        r_skid_v   <= 1'b0;
      end else if (w_acc) begin
        r_main_v   <= 1'b1;
        r_main_sel <= w_dec_sel;
        r_main_a   <= opa;
        r_main_b   <= opb;
        r_main_ill <= w_dec_ill;
      end else begin
        r_main_v   <= 1'b0;
        r_main_sel <= ALU_NOP;
        r_main_ill <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid_v   <= 1'b1;
      r_skid_sel <= w_dec_sel;
      r_skid_a   <= opa;
      r_skid_b   <= opb;
      r_skid_ill <= w_dec_ill;
    end
  end

  // Saturating count of accepted illegal ops; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc && w_dec_ill && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_main_v;
  assign sel         = r_main_sel;
  assign A           = r_main_a;
  assign B           = r_main_b;
  assign illegal     = r_main_ill;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_op_issue.sv
`timescale 1ns/1ps
module tb_alu_op_issue;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [1:0]    alu_op;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic [N-1:0]  opa;
  logic [N-1:0]  opb;
  logic          flush;
  logic          out_ready;

  logic          in_ready, out_valid, illegal;
  logic [3:0]    sel;
  logic [N-1:0]  A, B;
  logic [15:0]   illegal_cnt;

  logic          s_in_ready, s_out_valid, s_illegal;
  logic [3:0]    s_sel;
  logic [N-1:0]  s_A, s_B;
  logic [3:0]    s_cnt;

  always #5 clk = ~clk;

  alu_op_issue #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .opa(opa), .opb(opb),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .sel(sel),
    .A(A), .B(B), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_op_issue #(.N(N), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .opa(opa), .opb(opb),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .sel(s_sel),
    .A(s_A), .B(s_B), .illegal(s_illegal), .illegal_cnt(s_cnt)
  );

  typedef struct {
    logic [3:0]   sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ill;
  } ent_t;

  ent_t        q[$];
  int unsigned cnt_model;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic         exp_valid, exp_ready, exp_ill;
  logic [3:0]   exp_sel;
  logic [N-1:0] exp_a, exp_b;
  logic [15:0]  exp_cnt;
  logic [3:0]   exp_cnt4;

  // Reference decode, by operation meaning: {illegal, sel}.
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'd0) return {1'b0, 4'd2};
    if (op == 2'd1) return {1'b0, 4'd6};
    if (f3 == 3'd0) return {1'b0, ((op == 2'd2) && f7) ? 4'd6 : 4'd2};
    if (f3 == 3'd7) return {1'b0, 4'd0};
    if (f3 == 3'd6) return {1'b0, 4'd1};
    return {1'b1, 4'd15};
  endfunction

  task automatic refresh_exp();
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() < 2);
    exp_sel   = exp_valid ? q[0].sel : 4'd15;
    exp_ill   = exp_valid ? q[0].ill : 1'b0;
    exp_a     = exp_valid ? q[0].a : '0;
    exp_b     = exp_valid ? q[0].b : '0;
    exp_cnt   = (cnt_model > 65535) ? 16'hFFFF : cnt_model[15:0];
    exp_cnt4  = (cnt_model > 15) ? 4'hF : cnt_model[3:0];
  endtask

  // One clock: the model follows the FIFO rules using the inputs at the edge.
  task automatic tick();
    ent_t       e;
    logic [4:0] d;
    bit         xfer, acc;
    @(posedge clk);
    d     = ref_decode(alu_op, funct3, funct7_5);
    e.sel = d[3:0];
    e.ill = d[4];
    e.a   = opa;
    e.b   = opb;
    xfer  = (q.size() != 0) && out_ready;
    acc   = in_valid && (q.size() < 2) && !flush;
    if (flush) q.delete();
    else begin
      if (xfer) q.delete(0);
      if (acc) q.push_back(e);
    end
    if (acc && e.ill) cnt_model++;
    #1;
    refresh_exp();
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    funct3   = f3;
    funct7_5 = f7;
    opa      = a;
    opb      = b;
  endtask

  task automatic drive_random_legal();
    logic [1:0] op;
    logic [2:0] f3;
    int         k;
    op = 2'($urandom_range(0, 3));
    k  = $urandom_range(0, 2);
    f3 = (op < 2) ? 3'($urandom_range(0, 7)) : ((k == 0) ? 3'd0 : (k == 1) ? 3'd7 : 3'd6);
    drive_op(op, f3, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; funct3 = '0; funct7_5 = 1'b0;
    opa = '0; opb = '0; flush = 1'b0; out_ready = 1'b0;
    q.delete(); cnt_model = 0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_checks++; if (sel !== 4'hF) begin n_fail++; $display("FAIL reset_sel got %h want f", sel); end
    n_checks++; if ((A !== '0) || (B !== '0)) begin n_fail++; $display("FAIL reset_ab got %h/%h want 0/0", A, B); end
    n_checks++; if ((illegal !== 1'b0) || (illegal_cnt !== 16'd0)) begin n_fail++; $display("FAIL reset_ill got %b/%0d want 0/0", illegal, illegal_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_op(2'b10, 3'b001, 1'b0, $urandom, $urandom);
      tick();
      n_checks++; if ((illegal !== 1'b1) || (sel !== 4'hF) || (illegal !== exp_ill)) begin n_fail++; $display("FAIL sat_ill[%0d] got %b/%h want 1/f", i, illegal, sel); end
      n_checks++; if (s_cnt !== exp_cnt4) begin n_fail++; $display("FAIL sat_cnt4[%0d] got %0d want %0d", i, s_cnt, exp_cnt4); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (s_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_final got %0d want 15", s_cnt); end
    n_checks++; if (illegal_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt16 got %0d want %0d", illegal_cnt, exp_cnt); end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int f7 = 0; f7 < 2; f7++) begin
          drive_op(2'(op), 3'(f3), 1'(f7), $urandom, $urandom);
          tick();
          n_checks++;
          if ((out_valid !== 1'b1) || (sel !== exp_sel) || (illegal !== exp_ill) || (A !== exp_a) || (B !== exp_b)) begin
            n_fail++;
            $display("FAIL decode op=%0d f3=%0d f7=%0d got v=%b sel=%h ill=%b want sel=%h ill=%b",
                     op, f3, f7, out_valid, sel, illegal, exp_sel, exp_ill);
          end
          if ((op == 2) && (f3 == 0) && (f7 == 1)) begin
            n_checks++; if (sel !== 4'b0110) begin n_fail++; $display("FAIL decode_sub got %h want 6", sel); end
          end
          if ((op == 2) && (f3 == 1)) begin
            n_checks++; if ((sel !== 4'hF) || (illegal !== 1'b1)) begin n_fail++; $display("FAIL decode_illegal got %h/%b want f/1", sel, illegal); end
          end
        end
    in_valid = 1'b0;
    tick();
    n_checks++; if ((out_valid !== 1'b0) || (sel !== 4'hF)) begin n_fail++; $display("FAIL decode_drain got %b/%h want 0/f", out_valid, sel); end
    n_checks++; if (illegal_cnt !== exp_cnt) begin n_fail++; $display("FAIL decode_cnt got %0d want %0d", illegal_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back_stall();
    out_ready = 1'b0;
    drive_op(2'b00, 3'd0, 1'b0, 32'd5, 32'd3);
    tick();
    drive_op(2'b01, 3'd0, 1'b0, 32'd5, 32'd3);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
      n_checks++; if ((out_valid !== 1'b1) || (sel !== 4'b0010) || (A !== 32'd5) || (B !== 32'd3)) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b sel=%h A=%0d B=%0d want 1/2/5/3", i, out_valid, sel, A, B); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (sel !== 4'b0010) begin n_fail++; $display("FAIL bp_x got %h want 2", sel); end
    tick();
    n_checks++; if ((out_valid !== 1'b1) || (sel !== 4'b0110) || (sel !== exp_sel)) begin n_fail++; $display("FAIL bp_y got v=%b sel=%h want 1/6", out_valid, sel); end
    n_checks++; if ((in_ready !== 1'b1) || (in_ready !== exp_ready)) begin n_fail++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_random_legal();
      tick();
      n_checks++;
      if ((out_valid !== 1'b1) || (in_ready !== 1'b1) || (sel !== exp_sel) || (A !== exp_a) || (B !== exp_b) || (illegal !== 1'b0)) begin
        n_fail++;
        $display("FAIL stream[%0d] got v=%b r=%b sel=%h A=%h want sel=%h A=%h", i, out_valid, in_ready, sel, A, exp_sel, exp_a);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    out_ready = 1'b0;
    drive_random_legal(); tick();
    drive_random_legal(); tick();
    n_checks++; if ((in_ready !== 1'b0) || (out_valid !== 1'b1)) begin n_fail++; $display("FAIL flush_full got r=%b v=%b want 0/1", in_ready, out_valid); end
    cnt_before = illegal_cnt;
    drive_op(2'b11, 3'b010, 1'b0, 32'hDEAD, 32'hBEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if ((out_valid !== 1'b0) || (in_ready !== 1'b1) || (sel !== 4'hF)) begin n_fail++; $display("FAIL flush_empty got v=%b r=%b sel=%h want 0/1/f", out_valid, in_ready, sel); end
    n_checks++; if ((illegal_cnt !== cnt_before) || (illegal_cnt !== exp_cnt)) begin n_fail++; $display("FAIL flush_cnt got %0d want %0d", illegal_cnt, cnt_before); end
    // The flushed op was presented while in_ready=0; repeat with in_ready=1.
    drive_op(2'b10, 3'b011, 1'b0, 32'h1234, 32'h5678);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ((out_valid !== 1'b0) || (illegal_cnt !== cnt_before)) begin n_fail++; $display("FAIL flush_drop[%0d] got v=%b cnt=%0d want 0/%0d", i, out_valid, illegal_cnt, cnt_before); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive_op(2'b10, 3'b101, 1'b0, $urandom, $urandom); tick();
    drive_random_legal(); tick();
    in_valid = 1'b0;
    n_checks++; if ((in_ready !== 1'b0) || (illegal_cnt !== exp_cnt) || (illegal_cnt == 16'd0)) begin n_fail++; $display("FAIL arst_pre got r=%b cnt=%0d want 0/%0d", in_ready, illegal_cnt, exp_cnt); end
    #3;
    rst_n = 1'b0;
    #1;
    q.delete(); cnt_model = 0; refresh_exp();
    n_checks++; if ((out_valid !== 1'b0) || (in_ready !== 1'b1) || (sel !== 4'hF)) begin n_fail++; $display("FAIL arst_ctrl got v=%b r=%b sel=%h want 0/1/f", out_valid, in_ready, sel); end
    n_checks++; if ((A !== '0) || (B !== '0) || (illegal !== 1'b0) || (illegal_cnt !== 16'd0)) begin n_fail++; $display("FAIL arst_data got A=%h B=%h ill=%b cnt=%0d want 0", A, B, illegal, illegal_cnt); end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive_op(2'b11, 3'b111, 1'b1, 32'hA5A5_0001, 32'h0F0F_0002);
    tick();
    in_valid = 1'b0;
    n_checks++; if ((out_valid !== 1'b1) || (sel !== 4'b0000) || (A !== 32'hA5A5_0001) || (B !== 32'h0F0F_0002)) begin n_fail++; $display("FAIL arst_first got v=%b sel=%h A=%h want 1/0/a5a50001", out_valid, sel, A); end
    tick();
    n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL arst_drain got %b want %b", out_valid, exp_valid); end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_decode();
    test_back_to_back_stall();
    test_stream();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
